fofb_link_arbiter: RTL
======================

Name: fofb_link_arbiter

Overview:
- Packet-level arbiter and sequencer between two 8-bit FOFB read-link streams and one downstream consumer. Single clock domain.
- Grants whole packets round-robin; a packet ends on the beat with TUSER=1. Once a packet is granted, its beats are never interleaved with the other link's beats.
- Enforces a maximum packet length and truncates runaway packets.
- Provides per-link packet and truncation counters for status readout.

Parameters:
- MAX_LEN, 256: maximum beats per packet, including the TUSER beat. Legal range 2..65535.
- CNT_W, 16: width of the status counters.

Ports:
- aclk  in  1  block clock
- aresetn  in  1  reset, asynchronous assert, active-low
- s00_tvalid  in  1  link 0 beat valid
- s00_tready  out  1  link 0 beat accepted
- s00_tdata  in  8  link 0 data
- s00_tuser  in  1  link 0 end-of-packet
- s01_tvalid, s01_tready, s01_tdata, s01_tuser: link 1, same as link 0
- m00_tvalid  out  1  output beat valid
- m00_tready  in  1  downstream ready
- m00_tdata  out  8  output data
- m00_tuser  out  1  output end-of-packet
- link_en  in  2  per-link enable; bit i gates link i
- grant  out  2  one-hot current owner; 00 when idle
- pkt_cnt0, pkt_cnt1  out  CNT_W  packets forwarded per link; wrap at 2^CNT_W
- trunc_cnt0, trunc_cnt1  out  CNT_W  packets truncated per link; wrap at 2^CNT_W

Behaviour:
- Reset values:
  - All outputs 0, all counters 0, state IDLE, last_grant=1.
  - With last_grant=1, link 0 wins the first contest.
- Output register:
  - One-deep registered stage drives m00_*.
  - Load when the stage is empty or m00_tready=1; on load m00_tvalid=1.
  - Clear m00_tvalid on m00_tready when nothing is loading.
  - m00_tdata/m00_tuser hold while m00_tvalid=1 and m00_tready=0.
- sXX_tready = (state==GRANTx or DRAINx) for that link AND (m00_tvalid==0 OR m00_tready==1).
  - In DRAINx, sXX_tready=1 regardless of the output stage.
  - Never asserted for the link that is not the owner.
- Latency: accepted beat appears on m00 the next cycle.
- States:
  - IDLE:
    - req_i = sXX_tvalid & link_en[i].
    - Only one req_i set: go to GRANTi.
    - Both set: go to the link != last_grant.
    - Neither set: stay in IDLE.
    - On leaving, last_grant is updated to the granted link.
    - No beats are accepted in IDLE, so a grant costs one bubble cycle.
  - GRANTx, per accepted beat, beat_cnt increments (counter reset on entry):
    - Beat with tuser=1: forward it, pkt_cntx++, beat_cnt:=0, go to IDLE.
    - Beat number MAX_LEN with tuser=0: forward it with m00_tuser forced to 1, pkt_cntx++, trunc_cntx++, go to DRAINx.
  - DRAINx:
    - Accept and discard link x beats; nothing is forwarded.
    - Leave for IDLE on the cycle a beat with tuser=1 is accepted.
- link_en:
  - Sampled only in IDLE.
  - Deasserting it mid-packet has no effect until the packet ends.
- Simultaneous events:
  - Packet end and a new request on the other link in the same cycle: the grant is decided the next cycle in IDLE, so a single link cannot monopolise the output.
  - Both links requesting continuously produces strict alternation of packets.
- Back-pressure:
  - With m00_tready=0 and the output stage full, the owner stalls.
  - beat_cnt counts accepted beats only.
- Reset mid-packet:
  - Everything returns immediately to reset values.
  - A partial packet on m00 is dropped; the downstream side must resynchronise on the next TUSER.
- Counters increment by 1 on the accepted beat and wrap silently.

Decomposition:
- Shared package fofb_link_pkg:
  - State enum {IDLE, GRANT0, GRANT1, DRAIN0, DRAIN1}.
  - Stream beat width constant LINK_DW=9 ({tuser, tdata}).
- Sub-module fofb_link_outreg: the one-deep registered output stage with tready back-pressure. Reusable by other link blocks.

Test Plan:
- Single packet: link 0 sends 4 beats 0x10..0x13, tuser on the last, link_en=11 -> m00 shows 0x10..0x13 one cycle after acceptance with tuser on 0x13; pkt_cnt0=1; grant=01 then 00.
- Contention: both links continuously send 3-beat packets -> output alternates link0, link1, link0, link1 packets, never interleaved; after 8 packets pkt_cnt0=4 and pkt_cnt1=4.
- Truncation: MAX_LEN=4, link 1 sends 7 beats with tuser on beat 7 -> 4 beats forwarded with tuser forced on beat 4; beats 5-7 dropped; trunc_cnt1=1, pkt_cnt1=1; returns to IDLE after beat 7.
- Back-pressure: m00_tready held low for 5 cycles mid-packet -> s00_tready low, m00_tdata stable, no beat lost or duplicated; output resumes in order.
- Enable: link_en=01 with link 1 requesting -> link 1 is never granted and s01_tready stays 0; clearing link_en[0] mid-packet still completes the packet.
- Reset: aresetn pulsed low mid-packet -> all outputs and counters 0 asynchronously; the first grant after release goes to link 0.

Source files
------------

// File: rtl/fofb_link_pkg.sv
// Shared types and constants for the FOFB read-link arbiter blocks.
package fofb_link_pkg;

  // Arbiter sequencing states: idle, forwarding a link, or discarding a runaway tail.
  typedef enum logic [2:0] {
    IDLE,
    GRANT0,
    GRANT1,
    DRAIN0,
    DRAIN1
  } state_e;

  // One stream beat is {tuser, tdata}.
  localparam int LINK_DW = 9;

  // Width of the per-packet beat counter; covers the full legal MAX_LEN range.
  localparam int BEAT_W = 16;

endpackage

// File: rtl/fofb_link_outreg.sv
// One-deep registered output stage with downstream tready back-pressure.
module fofb_link_outreg
  import fofb_link_pkg::*;
#(
  parameter int DW = LINK_DW
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_valid_i,
  input  logic [DW-1:0] load_data_i,
  output logic          ready_o,
  output logic          out_valid_o,
  output logic [DW-1:0] out_data_o,
  input  logic          out_ready_i
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  // The stage can take a new beat when it is empty or its current beat leaves this cycle.
  assign ready_o = !valid_q || out_ready_i;

  // Next-state: load on accept, hold data while stalled, empty when drained with nothing new.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (ready_o) begin
      valid_d = load_valid_i;
      if (load_valid_i) begin
        data_d = load_data_i;
      end
    end
  end

  // Output stage registers; reset drops any partial packet.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/fofb_link_arbiter.sv
// Packet-level round-robin arbiter between two 8-bit FOFB read links, with
// maximum-length truncation and per-link status counters.
module fofb_link_arbiter
  import fofb_link_pkg::*;
#(
  parameter int MAX_LEN = 256,
  parameter int CNT_W   = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             s00_tvalid,
  output logic             s00_tready,
  input  logic [7:0]       s00_tdata,
  input  logic             s00_tuser,
  input  logic             s01_tvalid,
  output logic             s01_tready,
  input  logic [7:0]       s01_tdata,
  input  logic             s01_tuser,
  output logic             m00_tvalid,
  input  logic             m00_tready,
  output logic [7:0]       m00_tdata,
  output logic             m00_tuser,
  input  logic [1:0]       link_en,
  output logic [1:0]       grant,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1,
  output logic [CNT_W-1:0] trunc_cnt0,
  output logic [CNT_W-1:0] trunc_cnt1
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

  state_e             state_q;
  logic               last_grant_q;
  logic [BEAT_W-1:0]  beat_cnt_q;
  logic [CNT_W-1:0]   pkt_cnt0_q, pkt_cnt1_q, trunc_cnt0_q, trunc_cnt1_q;

  logic               out_ready;
  logic               req0, req1, acc0, acc1;
  logic               owner1, at_limit, cur_tuser;
  logic [7:0]         cur_tdata;
  logic               fwd_valid;
  logic [LINK_DW-1:0] fwd_data, out_data;

  // Handshakes: the owner is ready when the output stage can take a beat; a draining owner always is.
  always_comb begin
    req0       = s00_tvalid && link_en[0];
    req1       = s01_tvalid && link_en[1];
    s00_tready = ((state_q == GRANT0) && out_ready) || (state_q == DRAIN0);
    s01_tready = ((state_q == GRANT1) && out_ready) || (state_q == DRAIN1);
    acc0       = s00_tvalid && s00_tready;
    acc1       = s01_tvalid && s01_tready;
    owner1     = (state_q == GRANT1);
    cur_tuser  = owner1 ? s01_tuser : s00_tuser;
    cur_tdata  = owner1 ? s01_tdata : s00_tdata;
    at_limit   = (beat_cnt_q == LAST_BEAT);
    fwd_valid  = ((state_q == GRANT0) && acc0) || ((state_q == GRANT1) && acc1);
    fwd_data   = {cur_tuser || at_limit, cur_tdata};
    grant      = {(state_q == GRANT1) || (state_q == DRAIN1),
                  (state_q == GRANT0) || (state_q == DRAIN0)};
  end

  // Arbitration FSM with beat counting, truncation and status counters.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= '0;
      pkt_cnt0_q   <= '0;
      pkt_cnt1_q   <= '0;
      trunc_cnt0_q <= '0;
      trunc_cnt1_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          beat_cnt_q <= '0;
          if (req0 && req1) begin
            if (last_grant_q) begin
              state_q      <= GRANT0;
              last_grant_q <= 1'b0;
            end else begin
              state_q      <= GRANT1;
              last_grant_q <= 1'b1;
            end
          end else if (req0) begin
            state_q      <= GRANT0;
            last_grant_q <= 1'b0;
          end else if (req1) begin
            state_q      <= GRANT1;
            last_grant_q <= 1'b1;
          end
        end
        GRANT0: begin
          if (acc0) begin
            if (s00_tuser) begin
              pkt_cnt0_q <= pkt_cnt0_q + CNT_ONE;
              beat_cnt_q <= '0;
              state_q    <= IDLE;
            end else if (at_limit) begin
              pkt_cnt0_q   <= pkt_cnt0_q + CNT_ONE;
              trunc_cnt0_q <= trunc_cnt0_q + CNT_ONE;
              beat_cnt_q   <= '0;
              state_q      <= DRAIN0;
            end else begin
              beat_cnt_q <= beat_cnt_q + BEAT_ONE;
            end
          end
        end
        GRANT1: begin
          if (acc1) begin
            if (s01_tuser) begin
              pkt_cnt1_q <= pkt_cnt1_q + CNT_ONE;
              beat_cnt_q <= '0;
              state_q    <= IDLE;
            end else if (at_limit) begin
              pkt_cnt1_q   <= pkt_cnt1_q + CNT_ONE;
              trunc_cnt1_q <= trunc_cnt1_q + CNT_ONE;
              beat_cnt_q   <= '0;
              state_q      <= DRAIN1;
            end else begin
              beat_cnt_q <= beat_cnt_q + BEAT_ONE;
            end
          end
        end
        DRAIN0: begin
          if (acc0 && s00_tuser) begin
            state_q <= IDLE;
          end
        end
        DRAIN1: begin
          if (acc1 && s01_tuser) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  fofb_link_outreg #(
    .DW(LINK_DW)
  ) u_outreg (
    .clk_i        (aclk),
    .rst_ni       (aresetn),
    .load_valid_i (fwd_valid),
    .load_data_i  (fwd_data),
    .ready_o      (out_ready),
    .out_valid_o  (m00_tvalid),
    .out_data_o   (out_data),
    .out_ready_i  (m00_tready)
  );

  assign m00_tuser  = out_data[8];
  assign m00_tdata  = out_data[7:0];
  assign pkt_cnt0   = pkt_cnt0_q;
  assign pkt_cnt1   = pkt_cnt1_q;
  assign trunc_cnt0 = trunc_cnt0_q;
  assign trunc_cnt1 = trunc_cnt1_q;

endmodule
